// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA neighbourhood front end and its interpolators.
package cfa_pkg;

    localparam int CFA_DATA_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        BUBBLE,
        FLUSH
    } cfa_state_t;

    // Bayer phase of a pixel as {row_odd, col_odd}.
    typedef enum logic [1:0] {
        PH_EVEN_EVEN = 2'b00,
        PH_EVEN_ODD  = 2'b01,
        PH_ODD_EVEN  = 2'b10,
        PH_ODD_ODD   = 2'b11
    } cfa_phase_t;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/cfa_line_buffer.sv
// One line of pixel storage; the read returns the old word at addr while the
// same edge overwrites it, so two instances chain row r-1 into row r-2.
module cfa_line_buffer
    import cfa_pkg::*;
#(
    parameter int DATA_W = CFA_DATA_W,
    parameter int DEPTH  = 640,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/cfa_cross_window.sv
// Streaming cross-neighbourhood generator for Bayer CFA interpolation.
// Each accepted pixel (r,c) completes the window centred at (r-1,c-1).
module cfa_cross_window
    import cfa_pkg::*;
#(
    parameter int DATA_W = CFA_DATA_W,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_pix,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] center,
    output logic [DATA_W-1:0] v_m1,
    output logic [DATA_W-1:0] v_p1,
    output logic [DATA_W-1:0] h_m1,
    output logic [DATA_W-1:0] h_p1,
    output logic              row_odd,
    output logic              col_odd,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_eof
);

    // Column counter doubles as the flush sequencer, which runs to IMG_W+1.
    localparam int CW = clog2(IMG_W + 2);
    localparam int RW = clog2(IMG_H);
    localparam int AW = clog2(IMG_W);

    cfa_state_t        state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] mid0, mid1, top0, bot0;
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [AW-1:0]     lb_addr;
    logic              lb_we, accept, last_col, emit, step;
    logic [RW-1:0]     o_row;
    logic [CW-1:0]     o_col;
    logic [DATA_W-1:0] h_left, h_right, v_up, v_down;

    cfa_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .we(lb_we), .addr(lb_addr), .wr_data(in_pix), .rd_data(lb1_rd)
    );

    cfa_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb2 (
        .clk(clk), .we(lb_we), .addr(lb_addr), .wr_data(lb1_rd), .rd_data(lb2_rd)
    );

    always_comb begin
        accept   = in_valid && in_ready;
        last_col = (col == CW'(IMG_W - 1));
        lb_we    = accept && (in_sof || state != IDLE);
        lb_addr  = (accept && in_sof) ? '0 : col[AW-1:0];
        emit     = 1'b0;
        step     = 1'b0;
        case (state)
            RUN: begin
                emit = accept && !in_sof && (col != '0);
                step = accept && !in_sof;
            end
            BUBBLE: emit = 1'b1;
            // Replays the last row from the buffers with no new input pixels.
            FLUSH: begin
                emit = (col != '0) && (col <= CW'(IMG_W));
                step = (col < CW'(IMG_W));
            end
            default: ;
        endcase
        o_row   = (state == FLUSH) ? RW'(IMG_H - 1) : row - RW'(1);
        o_col   = (state == BUBBLE) ? CW'(IMG_W - 1) : col - CW'(1);
        h_right = (o_col == CW'(IMG_W - 1)) ? mid1 : lb1_rd;
        h_left  = (o_col == '0) ? lb1_rd : mid1;
        v_up    = (o_row == '0) ? bot0 : top0;
        v_down  = (o_row == RW'(IMG_H - 1)) ? top0 : bot0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            in_ready  <= 1'b0;
            mid0      <= '0;
            mid1      <= '0;
            top0      <= '0;
            bot0      <= '0;
            center    <= '0;
            v_m1      <= '0;
            v_p1      <= '0;
            h_m1      <= '0;
            h_p1      <= '0;
            row_odd   <= 1'b0;
            col_odd   <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            if (emit) begin
                out_valid <= 1'b1;
                center    <= mid0;
                v_m1      <= v_up;
                v_p1      <= v_down;
                h_m1      <= h_left;
                h_p1      <= h_right;
                row_odd   <= o_row[0];
                col_odd   <= o_col[0];
                out_sof   <= (o_row == '0) && (o_col == '0);
                out_eof   <= (o_row == RW'(IMG_H - 1)) && (o_col == CW'(IMG_W - 1));
            end
            if (step) begin
                mid1 <= mid0;
                mid0 <= lb1_rd;
                top0 <= lb2_rd;
                bot0 <= in_pix;
            end
            // A start-of-frame pixel always restarts at (0,0), abandoning any frame in progress.
            if (accept && in_sof) begin
                state <= FILL;
                row   <= '0;
                col   <= CW'(1);
            end else begin
                unique case (state)
                    IDLE: ;
                    FILL: begin
                        if (accept) begin
                            if (last_col) begin
                                col   <= '0;
                                row   <= RW'(1);
                                state <= RUN;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            if (last_col) begin
                                col      <= '0;
                                state    <= BUBBLE;
                                in_ready <= 1'b0;
                            end else begin
                                col <= col + CW'(1);
                            end
                        end
                    end
                    BUBBLE: begin
                        if (row == RW'(IMG_H - 1)) begin
                            state    <= FLUSH;
                            col      <= '0;
                            in_ready <= 1'b0;
                        end else begin
                            row   <= row + RW'(1);
                            state <= RUN;
                        end
                    end
                    FLUSH: begin
                        if (col == CW'(IMG_W + 1)) begin
                            state <= IDLE;
                            col   <= '0;
                            row   <= '0;
                        end else begin
                            col      <= col + CW'(1);
                            in_ready <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
